// File: rtl/coin_input_conditioner.sv
// Coin sensor conditioner: synchronize, debounce and edge-detect two coin sensors, then queue coin events
// and release them as single-cycle N/D pulses that never overlap a dispense. Optional macro: COIN_CREDIT_STATS_EN.
module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    localparam int LW             = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          nickel_raw,
    input  logic          dime_raw,
    input  logic          newspaper,
    output logic          N,
    output logic          D,
    output logic          coin_return,
    output logic [LW-1:0] fifo_level
`ifdef COIN_CREDIT_STATS_EN
    ,
    output logic [15:0]   credit_total
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw_w;
    logic [1:0] rise_w;

    assign raw_w = {dime_raw, nickel_raw};

    // Index 0 is the nickel sensor, index 1 the dime sensor.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sensor
            logic       sync1_q;
            logic       sync2_q;
            logic       stable_q;
            logic       stable_d;
            logic       prev_q;
            logic [7:0] cnt_q;
            logic [7:0] cnt_d;

            always_comb begin
                stable_d = stable_q;
                cnt_d    = 8'd0;
                if (sync2_q != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = ~stable_q;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q  <= 1'b0;
                    sync2_q  <= 1'b0;
                    cnt_q    <= 8'd0;
                    stable_q <= 1'b0;
                    prev_q   <= 1'b0;
                end else begin
                    sync1_q  <= raw_w[gi];
                    sync2_q  <= sync1_q;
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                    prev_q   <= stable_q;
                end
            end

            assign rise_w[gi] = stable_q & ~prev_q;
        end
    endgenerate

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          mem_q [FIFO_DEPTH];
    logic          pend_n_q, pend_n_d;
    logic          pend_d_q, pend_d_d;
    logic          n_q, n_d;
    logic          d_q, d_d;
    logic          ret_q, ret_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr_req;
    logic          wr_bit;
    logic          full_w;
    logic          empty_w;
    logic          push_w;
    logic          pop_w;
    logic          head_w;

    assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign head_w  = mem_q[rd_ptr_q[AW-1:0]];

    // One write per edge: a held dime goes first, then nickels, then a fresh dime;
    // whatever loses arbitration waits in its pending flag for the next edge.
    always_comb begin
        wr_req   = 1'b0;
        wr_bit   = 1'b0;
        pend_n_d = pend_n_q | rise_w[0];
        pend_d_d = pend_d_q | rise_w[1];
        if (pend_d_q) begin
            wr_req   = 1'b1;
            wr_bit   = 1'b1;
            pend_d_d = rise_w[1];
        end else if (pend_n_q || rise_w[0]) begin
            wr_req   = 1'b1;
            wr_bit   = 1'b0;
            pend_n_d = pend_n_q & rise_w[0];
        end else if (rise_w[1]) begin
            wr_req   = 1'b1;
            wr_bit   = 1'b1;
            pend_d_d = 1'b0;
        end
    end

    // Pop only when the previous cycle was idle, so pulses are always separated by a gap.
    always_comb begin
        push_w   = wr_req & ~full_w;
        pop_w    = ~empty_w & ~newspaper & ~n_q & ~d_q;
        ret_d    = wr_req & full_w;
        n_d      = pop_w & ~head_w;
        d_d      = pop_w & head_w;
        wr_ptr_d = push_w ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_w ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push_w, pop_w})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pend_n_q <= 1'b0;
            pend_d_q <= 1'b0;
            n_q      <= 1'b0;
            d_q      <= 1'b0;
            ret_q    <= 1'b0;
            level_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pend_n_q <= pend_n_d;
            pend_d_q <= pend_d_d;
            n_q      <= n_d;
            d_q      <= d_d;
            ret_q    <= ret_d;
            level_q  <= level_d;
            if (push_w) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr_bit;
            end
        end
    end

    assign N           = n_q;
    assign D           = d_q;
    assign coin_return = ret_q;
    assign fifo_level  = level_q;

`ifdef COIN_CREDIT_STATS_EN
    logic [15:0] credit_q;
    logic [16:0] credit_sum;

    assign credit_sum = {1'b0, credit_q} + (n_d ? 17'd5 : 17'd0) + (d_d ? 17'd10 : 17'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= 16'd0;
        end else begin
            credit_q <= credit_sum[16] ? 16'hFFFF : credit_sum[15:0];
        end
    end

    assign credit_total = credit_q;
`endif

endmodule
